// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

   // Receive FSM states, one transition per detected ps2_clk falling edge
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
   localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
   localparam int         PS2_FRAME_BITS   = 11;

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-flop synchroniser with a falling-edge detector on the synchronised level.
module ps2_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;
   logic              w_level;

   assign w_level = r_sync[STAGES-1];

   // Shift the raw line through the synchroniser; idle PS/2 lines are high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
         r_prev <= w_level;
      end
   end

   // High for one cycle when the synchronised level goes 1 -> 0
   assign o_fall = r_prev & ~w_level;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frames bytes off ps2_clk/ps2_data, absorbs E0/F0
// prefixes and emits one code/new_code/makeBreak/extended event per key.
// Optional build macro PS2_SCAN_RX_TIMEOUT_EN adds a watchdog that drops a
// partial frame after TIMEOUT_CYCLES clocks without a ps2_clk falling edge.
// Valid/strobe semantics: new_code is a one-cycle valid with no ready; code,
// makeBreak and extended are qualified by it and hold until the next event.
module ps2_scan_rx
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       new_code,
   output logic       makeBreak,
   output logic       extended,
   output logic       frame_err,
   output logic [1:0] o_state
);

   ps2_state_t             r_state, w_state_nxt;
   logic [2:0]             r_cnt, w_cnt_nxt;
   logic [7:0]             r_shift, w_shift_nxt;
   logic                   r_par, w_par_nxt;
   logic [SYNC_STAGES-1:0] r_dsync;
   logic                   w_data;
   logic                   w_fall;
   logic                   w_stop_ok, w_stop_bad;
   logic                   w_timeout;
   logic [7:0]             r_byte;
   logic                   r_byte_vld, r_err_pend;
   logic                   r_ext, r_brk;

   assign o_state = r_state;

   ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (ps2_clk),
      .o_fall  (w_fall)
   );

   // Plain synchroniser for data, same depth so it lines up with the clock edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_dsync <= '1;
      else        r_dsync <= {r_dsync[SYNC_STAGES-2:0], ps2_data};
   end
   assign w_data = r_dsync[SYNC_STAGES-1];

`ifdef PS2_SCAN_RX_TIMEOUT_EN
   localparam int LP_TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [LP_TO_W-1:0] r_to_cnt;

   // Count clocks since the last falling edge while a frame is in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             r_to_cnt <= '0;
      else if (r_state == ST_IDLE || w_fall)  r_to_cnt <= '0;
      else                                    r_to_cnt <= r_to_cnt + 1'b1;
   end
   assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                      (r_to_cnt == LP_TO_W'(TIMEOUT_CYCLES - 1));
`else
   // No watchdog in this build: constant-false for any legal TIMEOUT_CYCLES
   assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

   // Receive FSM state register and bit shifter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 3'd0;
         r_shift <= 8'h00;
         r_par   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
      end
   end

   // Next-state: advance one frame bit per falling edge, judge the frame at stop
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_stop_ok   = 1'b0;
      w_stop_bad  = 1'b0;
      if (w_timeout) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = 3'd0;
      end else if (w_fall) begin
         case (r_state)
            ST_IDLE: begin
               // A high start bit is a line glitch: ignore it silently
               if (!w_data) begin
                  w_state_nxt = ST_DATA;
                  w_cnt_nxt   = 3'd0;
               end
            end
            ST_DATA: begin
               w_shift_nxt[r_cnt] = w_data;
               if (r_cnt == 3'd7) w_state_nxt = ST_PARITY;
               else               w_cnt_nxt   = r_cnt + 3'd1;
            end
            ST_PARITY: begin
               w_par_nxt   = w_data;
               w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
               w_state_nxt = ST_IDLE;
               if (w_data && (^r_shift ^ r_par)) w_stop_ok  = 1'b1;
               else                              w_stop_bad = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Register the frame verdict so decode happens the cycle after the stop edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byte_vld <= 1'b0;
         r_err_pend <= 1'b0;
         r_byte     <= 8'h00;
      end else begin
         r_byte_vld <= w_stop_ok;
         r_err_pend <= w_stop_bad | w_timeout;
         if (w_stop_ok) r_byte <= r_shift;
      end
   end

   // Decode: absorb prefixes, emit events, pulse errors
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code      <= 8'h00;
         new_code  <= 1'b0;
         makeBreak <= 1'b0;
         extended  <= 1'b0;
         frame_err <= 1'b0;
         r_ext     <= 1'b0;
         r_brk     <= 1'b0;
      end else begin
         new_code  <= 1'b0;
         frame_err <= 1'b0;
         if (r_err_pend) begin
            frame_err <= 1'b1;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
         end else if (r_byte_vld) begin
            if (r_byte == PS2_EXT_PREFIX) begin
               r_ext <= 1'b1;
            end else if (r_byte == PS2_BREAK_PREFIX) begin
               r_brk <= 1'b1;
            end else begin
               code      <= r_byte;
               makeBreak <= ~r_brk;
               extended  <= r_ext;
               new_code  <= 1'b1;
               r_ext     <= 1'b0;
               r_brk     <= 1'b0;
            end
         end
      end
   end

endmodule
